// File: rtl/minutes_seconds_register_if.sv
// Bus bundle for one minutes/seconds BCD counter stage.
// The master side drives the count enable; the slave (the counter) returns
// the registered digits and the combinational rollover flag.
interface minutes_seconds_register_if;
    logic       en;
    logic       overflow;
    logic [3:0] data_msd;
    logic [3:0] data_lsd;

    modport master (
        output en,
        input  overflow,
        input  data_msd,
        input  data_lsd
    );

    modport slave (
        input  en,
        output overflow,
        output data_msd,
        output data_lsd
    );
endinterface

// File: rtl/minutes_seconds_register.sv
// Two-digit BCD modulo-(MSD_MAX+1)(LSD_MAX+1) counter, 00..59 by default.
// Used for both the seconds and the minutes field of the clock; stages cascade
// by enabling the next one with overflow & en of the previous one, so 59:59
// rolls to 00:00 on a single edge.
// Out-of-range digit codes are treated as "at max", so the next enabled
// increment forces that digit back to 0 and the counter recovers by itself.
module minutes_seconds_register #(
    parameter int MSD_MAX = 5,
    parameter int LSD_MAX = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    minutes_seconds_register_if.slave bus
);

    localparam logic [3:0] MSD_TOP = 4'(MSD_MAX);
    localparam logic [3:0] LSD_TOP = 4'(LSD_MAX);

    logic [3:0] msd;
    logic [3:0] lsd;
    logic       lsd_at_max;
    logic       msd_at_max;

    // ">=" rather than "==" so illegal codes behave like the top value.
    assign lsd_at_max = (lsd >= LSD_TOP);
    assign msd_at_max = (msd >= MSD_TOP);

    // Digit registers: reset wins over enable; units carry into tens.
    always_ff @(posedge clk) begin
        if (reset) begin
            msd <= 4'd0;
            lsd <= 4'd0;
        end else if (bus.en) begin
            if (lsd_at_max) begin
                lsd <= 4'd0;
                if (msd_at_max) begin
                    msd <= 4'd0;
                end else begin
                    msd <= msd + 4'd1;
                end
            end else begin
                lsd <= lsd + 4'd1;
            end
        end
    end

    // Rollover flag is purely combinational so the downstream stage sees it
    // in the same cycle and updates on the same edge as this one.
    assign bus.overflow = bus.en & lsd_at_max & msd_at_max;
    assign bus.data_msd = msd;
    assign bus.data_lsd = lsd;

endmodule

// File: tb/tb_minutes_seconds_register.sv
// Bench for minutes_seconds_register: seconds and minutes stages cascaded
// exactly as in the clock (minutes en = seconds overflow & tick).
module tb_minutes_seconds_register;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   exp_s;
    int   exp_m;

    minutes_seconds_register_if sec_if ();
    minutes_seconds_register_if min_if ();

    assign min_if.en = sec_if.overflow & sec_if.en;

    minutes_seconds_register dut_sec (
        .clk   (clk),
        .reset (reset),
        .bus   (sec_if.slave)
    );

    minutes_seconds_register dut_min (
        .clk   (clk),
        .reset (reset),
        .bus   (min_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_values();
        chk("sec_msd", int'(sec_if.data_msd), exp_s / 10);
        chk("sec_lsd", int'(sec_if.data_lsd), exp_s % 10);
        chk("min_msd", int'(min_if.data_msd), exp_m / 10);
        chk("min_lsd", int'(min_if.data_lsd), exp_m % 10);
    endtask

    // One clock: drive inputs, check overflow flags before the edge, then
    // advance the reference values and check the registered digits.
    task automatic tick(input logic e, input logic r);
        logic sec_ov;
        logic min_ov;
        sec_if.en = e;
        reset     = r;
        #1;
        sec_ov = e && (exp_s == 59);
        min_ov = sec_ov && (exp_m == 59);
        chk("sec_overflow", int'(sec_if.overflow), int'(sec_ov));
        chk("min_overflow", int'(min_if.overflow), int'(min_ov));
        @(posedge clk);
        #1;
        if (r) begin
            exp_s = 0;
            exp_m = 0;
        end else if (e) begin
            if (sec_ov) exp_m = (exp_m + 1) % 60;
            exp_s = (exp_s + 1) % 60;
        end
        chk_values();
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        exp_s     = 0;
        exp_m     = 0;
        sec_if.en = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        tick(1'b0, 1'b1);
        chk("reset_sec_ovf", int'(sec_if.overflow), 0);

        // 1. Hold for 10 clocks
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        chk("hold_value", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 0);

        // 2. Count 00..59, 60th edge -> 00, minutes step once
        for (int i = 1; i <= 60; i++) begin
            tick(1'b1, 1'b0);
            chk("count_seq", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), i % 60);
        end
        chk("count_min_after_wrap", int'(min_if.data_lsd), 1);

        // 3. Cascade from 00:00 for 3600 clocks
        tick(1'b0, 1'b1);
        for (int i = 1; i <= 3600; i++) begin
            tick(1'b1, 1'b0);
            if (i == 60)   chk("cascade_min_at_60", int'(min_if.data_lsd), 1);
            if (i == 3599) chk("cascade_5959_min_tens", int'(min_if.data_msd), 5);
        end
        chk("cascade_end_min", int'(min_if.data_msd) * 10 + int'(min_if.data_lsd), 0);
        chk("cascade_end_sec", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 0);

        // 4. Gated enable for 120 clocks: 60 counts, back to 00
        for (int i = 0; i < 120; i++) tick(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
        chk("gated_end_sec", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 0);
        chk("gated_end_min", int'(min_if.data_lsd), 1);

        // 5. Reset at 37 with en high
        tick(1'b0, 1'b1);
        for (int i = 0; i < 37; i++) tick(1'b1, 1'b0);
        chk("pre_reset_37", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 37);
        tick(1'b1, 1'b1);
        chk("mid_reset_val", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 0);
        chk("mid_reset_ovf", int'(sec_if.overflow), 0);
        tick(1'b1, 1'b0);
        chk("resume_01", int'(sec_if.data_lsd), 1);

        // 6. Boundaries: 09 -> 10 carry; 59 with en=0 holds
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        chk("at_09", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 9);
        tick(1'b1, 1'b0);
        chk("carry_10_msd", int'(sec_if.data_msd), 1);
        chk("carry_10_lsd", int'(sec_if.data_lsd), 0);
        for (int i = 0; i < 49; i++) tick(1'b1, 1'b0);
        chk("at_59", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 59);
        tick(1'b0, 1'b0);
        chk("hold_59_val", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 59);
        chk("hold_59_ovf", int'(sec_if.overflow), 0);
        tick(1'b1, 1'b0);
        chk("wrap_from_59", int'(sec_if.data_msd) * 10 + int'(sec_if.data_lsd), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
